bsearch_engine: RTL and testbench

BSEARCH_ENGINE -- requirements
Module: bsearch_engine

---
 rtl/bsearch_engine_if.sv | 28 ++
 rtl/bsearch_engine.sv | 99 +++++++++
 tb/tb_bsearch_engine.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bsearch_engine_if.sv
// Request/response and memory-read signals of the binary search engine.
// The client (master) owns the request inputs and returns the memory read data.
interface bsearch_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  start;
  logic [DATA_WIDTH-1:0] target;
  logic                  mode;
  logic [ADDR_WIDTH:0]   n_entries;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd_en;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;
  logic                  done;
  logic                  found;
  logic [ADDR_WIDTH:0]   result_idx;

  modport master (
    output start, target, mode, n_entries, mem_rdata,
    input  mem_addr, mem_rd_en, busy, done, found, result_idx
  );

  modport slave (
    input  start, target, mode, n_entries, mem_rdata,
    output mem_addr, mem_rd_en, busy, done, found, result_idx
  );
endinterface

// File: rtl/bsearch_engine.sv
// Binary search over an ascending table held in an external memory with
// RD_LATENCY-cycle reads; supports exact-match and lower-bound modes.
module bsearch_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_LATENCY = 1
) (
  input logic             clk,
  input logic             reset,
  bsearch_engine_if.slave bus
);
  localparam logic [1:0] WAIT_LAST = 2'((RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_COMPARE, S_DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH:0]   lo_reg, hi_reg;
  logic [DATA_WIDTH-1:0] target_reg;
  logic                  mode_reg;
  logic                  found_reg;
  logic [1:0]            wait_cnt_reg;

  // hi never exceeds 2^ADDR_WIDTH, so mid < hi always fits the address bus
  logic [ADDR_WIDTH:0]   mid, lo_upd, hi_upd;
  logic                  rd_less, rd_equal, exact_hit;

  always_comb begin
    mid       = lo_reg + ((hi_reg - lo_reg) >> 1);
    rd_less   = bus.mem_rdata < target_reg;
    rd_equal  = bus.mem_rdata == target_reg;
    lo_upd    = rd_less ? (mid + 1'b1) : lo_reg;
    hi_upd    = rd_less ? hi_reg : mid;
    exact_hit = !mode_reg && rd_equal;
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (bus.start) state_next = (bus.n_entries != '0) ? S_ISSUE : S_DONE;
      S_ISSUE:   state_next = (RD_LATENCY == 1) ? S_COMPARE : S_WAIT;
      S_WAIT:    if (wait_cnt_reg == WAIT_LAST) state_next = S_COMPARE;
      S_COMPARE: state_next = (exact_hit || lo_upd == hi_upd) ? S_DONE : S_ISSUE;
      S_DONE:    if (!bus.start) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Request inputs are only sampled in IDLE, so changes while busy are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      lo_reg       <= '0;
      hi_reg       <= '0;
      target_reg   <= '0;
      mode_reg     <= 1'b0;
      found_reg    <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (bus.start) begin
          target_reg <= bus.target;
          mode_reg   <= bus.mode;
          lo_reg     <= '0;
          hi_reg     <= bus.n_entries;
          found_reg  <= 1'b0;
        end
        S_ISSUE: wait_cnt_reg <= '0;
        S_WAIT:  wait_cnt_reg <= wait_cnt_reg + 1'b1;
        S_COMPARE: begin
          if (rd_equal) found_reg <= 1'b1;
          // An exact hit collapses the window onto mid so DONE reports lo.
          if (exact_hit) begin
            lo_reg <= mid;
            hi_reg <= mid;
          end else begin
            lo_reg <= lo_upd;
            hi_reg <= hi_upd;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy       = (state_reg == S_ISSUE) || (state_reg == S_WAIT) || (state_reg == S_COMPARE);
    bus.done       = state_reg == S_DONE;
    bus.found      = (state_reg == S_DONE) && found_reg;
    bus.result_idx = (state_reg == S_DONE) ? lo_reg : '0;
    bus.mem_rd_en  = state_reg == S_ISSUE;
    bus.mem_addr   = (state_reg == S_ISSUE) ? mid[ADDR_WIDTH-1:0] : '0;
  end
endmodule

// File: tb/tb_bsearch_engine.sv
// Directed checks of bsearch_engine at read latency 1 (dut_a) and 3 (dut_b),
// both reading one shared table.
module tb_bsearch_engine;
  logic clk = 1'b0;
  logic reset_a, reset_b;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  bsearch_engine_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) ifa ();
  bsearch_engine_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) ifb ();

  bsearch_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .RD_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset_a), .bus(ifa)
  );
  bsearch_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .RD_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset_b), .bus(ifb)
  );

  // Memory models return junk when not strobed, exposing wrong sample cycles.
  logic [7:0] mem [32];
  logic [7:0] pipe_a;
  logic [7:0] pipe_b [3];

  always @(posedge clk) pipe_a <= ifa.mem_rd_en ? mem[ifa.mem_addr] : 8'hA5;
  always @(posedge clk) pipe_b[0] <= ifb.mem_rd_en ? mem[ifb.mem_addr] : 8'hA5;
  generate
    for (genvar gi = 1; gi < 3; gi++) begin : g_pipe
      always @(posedge clk) pipe_b[gi] <= pipe_b[gi-1];
    end
  endgenerate
  assign ifa.mem_rdata = pipe_a;
  assign ifb.mem_rdata = pipe_b[2];

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [5:0] n,
                       input logic m, input logic [7:0] t);
    if (sel == 0) begin
      ifa.start = s; ifa.n_entries = n; ifa.mode = m; ifa.target = t;
    end else begin
      ifb.start = s; ifb.n_entries = n; ifb.mode = m; ifb.target = t;
    end
  endtask

  task automatic sample(input int sel, output logic rd, output logic dn,
                        output logic f, output logic [5:0] idx);
    rd  = (sel == 0) ? ifa.mem_rd_en  : ifb.mem_rd_en;
    dn  = (sel == 0) ? ifa.done       : ifb.done;
    f   = (sel == 0) ? ifa.found      : ifb.found;
    idx = (sel == 0) ? ifa.result_idx : ifb.result_idx;
  endtask

  // Runs one search, records probe count, probe spacing and latency, then
  // checks that DONE holds while start stays high and clears once it drops.
  task automatic run_search(input string tag, input int sel, input logic [5:0] n,
                            input logic m, input logic [7:0] t, input logic perturb,
                            output logic f, output logic [5:0] idx, output int probes,
                            output int gap_min, output int gap_max, output int lat);
    logic rd, dn, f2;
    logic [5:0] idx2;
    int last;
    bit hit;
    drive(sel, 1'b1, n, m, t);
    probes = 0; gap_min = 1000; gap_max = 0; last = -1; hit = 0; lat = -1;
    f = 1'b0; idx = '0;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      @(negedge clk);
      sample(sel, rd, dn, f, idx);
      if (rd) begin
        probes++;
        if (last >= 0) begin
          if (cyc - last < gap_min) gap_min = cyc - last;
          if (cyc - last > gap_max) gap_max = cyc - last;
        end
        last = cyc;
        if (perturb) drive(sel, 1'b1, 6'd3, ~m, ~t);
      end
      if (dn) begin
        hit = 1;
        lat = cyc + 1;
      end
    end
    check({tag, "_completed"}, int'(hit), 1);
    @(negedge clk);
    sample(sel, rd, dn, f2, idx2);
    check({tag, "_hold"}, int'({dn, f2, idx2}), int'({1'b1, f, idx}));
    drive(sel, 1'b0, n, m, t);
    @(negedge clk);
    sample(sel, rd, dn, f2, idx2);
    check({tag, "_release"}, int'(dn), 0);
  endtask

  task automatic load_even();
    for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i);
  endtask

  task automatic load_dups();
    logic [7:0] v [8];
    v = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd7, 8'd7, 8'd7, 8'd9};
    for (int i = 0; i < 32; i++) mem[i] = (i < 8) ? v[i] : 8'hFF;
  endtask

  logic       f;
  logic [5:0] idx;
  int         probes, gmin, gmax, lat, pulses;
  bit         saw;

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    drive(0, 1'b0, '0, 1'b0, '0);
    drive(1, 1'b0, '0, 1'b0, '0);
    load_even();
    repeat (3) @(negedge clk);
    check("reset_a_outputs", int'({ifa.busy, ifa.done, ifa.found, ifa.mem_rd_en}), 0);
    check("reset_a_idx_addr", int'({ifa.result_idx, ifa.mem_addr}), 0);
    reset_a = 1'b0; reset_b = 1'b0;
    @(negedge clk);

    run_search("exact_20", 0, 6'd32, 1'b0, 8'd20, 1'b0, f, idx, probes, gmin, gmax, lat);
    check("exact_20_found", int'(f), 1);
    check("exact_20_idx", int'(idx), 10);
    check("exact_20_probes_le6", int'(probes <= 6), 1);

    run_search("exact_21", 0, 6'd32, 1'b0, 8'd21, 1'b1, f, idx, probes, gmin, gmax, lat);
    check("exact_21_found", int'(f), 0);
    check("exact_21_idx", int'(idx), 11);
    check("exact_21_gap", gmax, 2);

    run_search("exact_100", 0, 6'd32, 1'b0, 8'd100, 1'b0, f, idx, probes, gmin, gmax, lat);
    check("exact_100_found", int'(f), 0);
    check("exact_100_idx", int'(idx), 32);

    run_search("exact_0", 0, 6'd32, 1'b0, 8'd0, 1'b0, f, idx, probes, gmin, gmax, lat);
    check("exact_0_found_idx", int'({f, idx}), int'({1'b1, 6'd0}));

    run_search("lb_62", 0, 6'd32, 1'b1, 8'd62, 1'b0, f, idx, probes, gmin, gmax, lat);
    check("lb_62_found_idx", int'({f, idx}), int'({1'b1, 6'd31}));

    load_dups();
    run_search("lb_dup7", 0, 6'd8, 1'b1, 8'd7, 1'b0, f, idx, probes, gmin, gmax, lat);
    check("lb_dup7_found", int'(f), 1);
    check("lb_dup7_idx", int'(idx), 3);

    run_search("lb_8", 0, 6'd8, 1'b1, 8'd8, 1'b0, f, idx, probes, gmin, gmax, lat);
    check("lb_8_found_idx", int'({f, idx}), int'({1'b0, 6'd7}));

    run_search("empty", 0, 6'd0, 1'b0, 8'd5, 1'b0, f, idx, probes, gmin, gmax, lat);
    check("empty_found_idx", int'({f, idx}), 0);
    check("empty_latency", lat, 1);
    check("empty_probes", probes, 0);

    load_even();
    run_search("lat3_1", 1, 6'd32, 1'b0, 8'd1, 1'b0, f, idx, probes, gmin, gmax, lat);
    check("lat3_1_found_idx", int'({f, idx}), int'({1'b0, 6'd1}));
    check("lat3_1_probes", probes, 6);
    check("lat3_1_gap_min", gmin, 4);
    check("lat3_1_gap_max", gmax, 4);

    run_search("lat3_62", 1, 6'd32, 1'b0, 8'd62, 1'b0, f, idx, probes, gmin, gmax, lat);
    check("lat3_62_found_idx", int'({f, idx}), int'({1'b1, 6'd31}));

    // Abort a latency-3 search while it waits on its first read.
    drive(1, 1'b1, 6'd32, 1'b0, 8'd50);
    saw = 0;
    for (int i = 0; i < 20 && !saw; i++) begin
      @(negedge clk);
      if (ifb.mem_rd_en) saw = 1;
    end
    check("abort_issue_seen", int'(saw), 1);
    @(negedge clk);
    check("abort_in_wait", int'({ifb.busy, ifb.mem_rd_en}), int'(2'b10));
    reset_b = 1'b1;
    drive(1, 1'b0, 6'd32, 1'b0, 8'd50);
    @(negedge clk);
    check("abort_outputs", int'({ifb.busy, ifb.done, ifb.found, ifb.mem_rd_en}), 0);
    check("abort_idx_addr", int'({ifb.result_idx, ifb.mem_addr}), 0);
    reset_b = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (ifb.mem_rd_en || ifb.done) pulses++;
    end
    check("abort_quiet", pulses, 0);

    run_search("after_abort", 1, 6'd32, 1'b0, 8'd40, 1'b0, f, idx, probes, gmin, gmax, lat);
    check("after_abort_found_idx", int'({f, idx}), int'({1'b1, 6'd20}));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
